mips_multicycle_controller: RTL

- Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks, using one shared memory and one ALU.
- Adds a memory wait-state handshake, an illegal-opcode flag and a parametrised ALU-control width.
- Sits between the instruction register (opcode/func fields) and the multicycle datapath.
- Drives all datapath muxes and enables, and computes the PC enable internally from zero.

---
 rtl/mips_multicycle_controller.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback over one shared memory and one ALU. Memory accesses
// stretch on mem_ready, undecoded opcodes pulse illegal_op in DECODE.
// Optional feature: define MIPS_MC_BNE_EN to add BNE (opcode 000101) via the
// BNEBR state; left undefined, BNE decodes as an illegal opcode.
module mips_multicycle_controller #(
    parameter int ALU_CTRL_W = 3,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            func,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  IorD,
    output logic                  MEMwrite,
    output logic                  IRwrite,
    output logic                  PCen,
    output logic [1:0]            PCsrc,
    output logic                  ALUsrcA,
    output logic [1:0]            ALUsrcB,
    output logic [ALU_CTRL_W-1:0] ALU_control,
    output logic                  REGwrite,
    output logic                  REGdist,
    output logic                  MEMtoREG,
    output logic                  illegal_op,
    output logic [STATE_W-1:0]    state_dbg
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;
`ifdef MIPS_MC_BNE_EN
    localparam logic [3:0] BNEBR   = 4'd12;
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state_q, state_d;
    logic [3:0] decode_target;
    logic       op_legal;
    logic       pc_write, branch_eq, branch_ne;
    logic [2:0] alu_code;

    // State register; reset is synchronous and aborts any instruction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode decode: DECODE's successor and whether the opcode is known.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        decode_target = FETCH;
        op_legal      = 1'b1;
        case (opcode)
            OP_LW, OP_SW: decode_target = MEMADR;
            OP_R:         decode_target = EXECUTE;
            OP_BEQ:       decode_target = BRANCH;
            OP_ADDI:      decode_target = ADDIEX;
            OP_J:         decode_target = JUMP;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       decode_target = BNEBR;
`endif
            default:      op_legal      = 1'b0;
        endcase
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE:  state_d = decode_target;
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode; write strobes are suppressed while reset is high.
    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MEMwrite   = 1'b0;
        IRwrite    = 1'b0;
        pc_write   = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        PCsrc      = 2'b00;
        ALUsrcA    = 1'b0;
        ALUsrcB    = 2'b00;
        alu_code   = ALU_ADD;
        REGwrite   = 1'b0;
        REGdist    = 1'b0;
        MEMtoREG   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req  = 1'b1;
                ALUsrcB  = 2'b01;
                IRwrite  = mem_ready;
                pc_write = mem_ready;
            end
            DECODE: begin
                ALUsrcB    = 2'b11;
                illegal_op = ~op_legal;
            end
            MEMADR, ADDIEX: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                REGwrite = 1'b1;
                MEMtoREG = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MEMwrite = 1'b1;
            end
            EXECUTE: begin
                ALUsrcA = 1'b1;
                case (func)
                    6'b100010: alu_code = ALU_SUB;
                    6'b100100: alu_code = ALU_AND;
                    6'b100101: alu_code = ALU_OR;
                    6'b101010: alu_code = ALU_SLT;
                    default:   alu_code = ALU_ADD;
                endcase
            end
            ALUWB: begin
                REGwrite = 1'b1;
                REGdist  = 1'b1;
            end
            BRANCH: begin
                ALUsrcA   = 1'b1;
                alu_code  = ALU_SUB;
                branch_eq = 1'b1;
                PCsrc     = 2'b01;
            end
`ifdef MIPS_MC_BNE_EN
            BNEBR: begin
                ALUsrcA   = 1'b1;
                alu_code  = ALU_SUB;
                branch_ne = 1'b1;
                PCsrc     = 2'b01;
            end
`endif
            ADDIWB: begin
                REGwrite = 1'b1;
            end
            JUMP: begin
                pc_write = 1'b1;
                PCsrc    = 2'b10;
            end
            default: ;
        endcase
        if (reset) begin
            MEMwrite  = 1'b0;
            REGwrite  = 1'b0;
            IRwrite   = 1'b0;
            pc_write  = 1'b0;
            branch_eq = 1'b0;
            branch_ne = 1'b0;
        end
    end

    assign PCen        = pc_write | (branch_eq & zero) | (branch_ne & ~zero);
    assign ALU_control = ALU_CTRL_W'(alu_code);
    assign state_dbg   = STATE_W'(state_q);

endmodule
